// File: rtl/if_fetch_pc.sv
// Fetch-stage front end: owns the fetch PC and a single-outstanding instruction-memory port.
// It feeds the IF/ID register through a 1-entry skid buffer, with stall and flush support.
module if_fetch_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_instr_o
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetchState_e;

    fetchState_e state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ifidValid_q, ifidValid_d;
    logic [31:0] ifidPc_q, ifidPc_d;
    logic [31:0] ifidInstr_q, ifidInstr_d;
    logic        skidValid_q, skidValid_d;
    logic [31:0] skidPc_q, skidPc_d;
    logic [31:0] skidInstr_q, skidInstr_d;

    logic [31:0] redirectTarget;
    logic        reqFire;
    logic        deliver;

    assign redirectTarget = redirect_pc_i & 32'hFFFF_FFFC;
    // A full skid buffer blocks new requests, so at most two words are ever held.
    assign imem_req_o     = rst && (state_q == FETCH) && !skidValid_q;
    assign reqFire        = imem_req_o && imem_gnt_i;
    assign deliver        = (state_q == WAIT) && imem_rvalid_i && !redirect_i;

    assign pc_o         = pc_q;
    assign imem_addr_o  = pc_q;
    assign ifid_valid_o = ifidValid_q;
    assign ifid_pc_o    = ifidPc_q;
    assign ifid_instr_o = ifidInstr_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            FETCH: begin
                if (reqFire) begin
                    state_d = redirect_i ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = FETCH;
                    if (!redirect_i) begin
                        pc_d = pc_q + 32'd4;
                    end
                end else if (redirect_i) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid_i) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
        if (redirect_i) begin
            pc_d = redirectTarget;
        end
    end

    // Flush beats stall; the skid drains before any fresh word can arrive.
    always_comb begin
        ifidValid_d = ifidValid_q;
        ifidPc_d    = ifidPc_q;
        ifidInstr_d = ifidInstr_q;
        skidValid_d = skidValid_q;
        skidPc_d    = skidPc_q;
        skidInstr_d = skidInstr_q;
        if (redirect_i) begin
            ifidValid_d = 1'b0;
            skidValid_d = 1'b0;
        end else if (skidValid_q) begin
            if (!stall_i) begin
                ifidValid_d = 1'b1;
                ifidPc_d    = skidPc_q;
                ifidInstr_d = skidInstr_q;
                skidValid_d = 1'b0;
            end
        end else if (deliver) begin
            if (!stall_i || !ifidValid_q) begin
                ifidValid_d = 1'b1;
                ifidPc_d    = pc_q;
                ifidInstr_d = imem_rdata_i;
            end else begin
                skidValid_d = 1'b1;
                skidPc_d    = pc_q;
                skidInstr_d = imem_rdata_i;
            end
        end else if (!stall_i) begin
            ifidValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            ifidValid_q <= 1'b0;
            ifidPc_q    <= 32'h0000_0000;
            ifidInstr_q <= NOP;
            skidValid_q <= 1'b0;
            skidPc_q    <= 32'h0000_0000;
            skidInstr_q <= NOP;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ifidValid_q <= ifidValid_d;
            ifidPc_q    <= ifidPc_d;
            ifidInstr_q <= ifidInstr_d;
            skidValid_q <= skidValid_d;
            skidPc_q    <= skidPc_d;
            skidInstr_q <= skidInstr_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_pc.sv
// Directed bench for if_fetch_pc: an instruction-memory model plus a scoreboard of
// expected IF/ID words.
module tb_if_fetch_pc;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] pc_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_instr_o;

    always #5 clk = ~clk;

    if_fetch_pc #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .pc_o          (pc_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .ifid_valid_o  (ifid_valid_o),
        .ifid_pc_o     (ifid_pc_o),
        .ifid_instr_o  (ifid_instr_o)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifidWord_t;

    int          testCount = 0;
    int          failCount = 0;
    ifidWord_t   expQ[$];
    logic        gntAllow;
    int          memLatency;
    logic        memBusy;
    logic        memStale;
    int          memCount;
    logic [31:0] memAddr;
    logic [31:0] expNextAddr;
    logic        modelValid;
    logic [31:0] modelPc;
    logic [31:0] modelInstr;
    logic        reqSeen;
    logic [31:0] addrSeen;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        expQ.delete();
        memBusy     = 1'b0;
        memStale    = 1'b0;
        memCount    = 0;
        memAddr     = 32'h0;
        expNextAddr = RESET_PC;
        modelValid  = 1'b0;
        modelPc     = 32'h0;
        modelInstr  = NOP;
    endtask

    // One clock: memory model drives the port, the scoreboard tracks what the edge
    // accepted/returned, and IF/ID is compared against the expected word stream.
    task automatic applyStimulus();
        logic      rvDriven;
        logic      accepted;
        ifidWord_t w;
        imem_rvalid_i = memBusy && (memCount == 0);
        imem_rdata_i  = imem_rvalid_i ? (memAddr ^ DATA_KEY) : 32'hDEAD_BEEF;
        imem_gnt_i    = gntAllow;
        #1;
        reqSeen  = imem_req_o;
        addrSeen = imem_addr_o;
        rvDriven = imem_rvalid_i;
        accepted = reqSeen && imem_gnt_i;
        @(posedge clk);
        if (rvDriven) begin
            if (!memStale && !redirect_i) begin
                w.pc    = memAddr;
                w.instr = memAddr ^ DATA_KEY;
                expQ.push_back(w);
            end
            memBusy  = 1'b0;
            memStale = 1'b0;
        end else if (memBusy) begin
            memCount--;
            if (redirect_i) memStale = 1'b1;
        end
        if (accepted) begin
            checkOutput("single_outstanding", 32'(memBusy), 32'd0);
            checkOutput("fetch_addr", addrSeen, expNextAddr);
            memBusy     = 1'b1;
            memStale    = redirect_i;
            memAddr     = expNextAddr;
            memCount    = memLatency - 1;
            expNextAddr = expNextAddr + 32'd4;
        end
        if (redirect_i) begin
            expQ.delete();
            expNextAddr = redirect_pc_i & 32'hFFFF_FFFC;
        end
        @(negedge clk);
        if (redirect_i) begin
            modelValid = 1'b0;
            checkOutput("flush_valid", 32'(ifid_valid_o), 32'd0);
        end else if (stall_i && modelValid) begin
            checkOutput("hold_valid", 32'(ifid_valid_o), 32'd1);
            checkOutput("hold_pc", ifid_pc_o, modelPc);
            checkOutput("hold_instr", ifid_instr_o, modelInstr);
        end else if (expQ.size() > 0) begin
            w          = expQ.pop_front();
            modelValid = 1'b1;
            modelPc    = w.pc;
            modelInstr = w.instr;
            checkOutput("load_valid", 32'(ifid_valid_o), 32'd1);
            checkOutput("load_pc", ifid_pc_o, w.pc);
            checkOutput("load_instr", ifid_instr_o, w.instr);
        end else begin
            modelValid = 1'b0;
            checkOutput("idle_valid", 32'(ifid_valid_o), 32'd0);
        end
    endtask

    task automatic runUntilValid(input string tag);
        int n = 0;
        while (ifid_valid_o !== 1'b1 && n < 20) begin
            applyStimulus();
            n++;
        end
        checkOutput(tag, 32'(ifid_valid_o), 32'd1);
    endtask

    initial begin
        rst           = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        gntAllow      = 1'b1;
        memLatency    = 1;
        reqSeen       = 1'b0;
        addrSeen      = 32'h0;
        resetModel();
        repeat (2) @(negedge clk);
        checkOutput("rst_req", 32'(imem_req_o), 32'd0);
        checkOutput("rst_pc", pc_o, RESET_PC);
        checkOutput("rst_valid", 32'(ifid_valid_o), 32'd0);
        checkOutput("rst_ifid_pc", ifid_pc_o, 32'h0);
        checkOutput("rst_ifid_instr", ifid_instr_o, NOP);
        rst = 1'b1;
        #1;
        checkOutput("release_req", 32'(imem_req_o), 32'd1);
        checkOutput("release_addr", imem_addr_o, RESET_PC);

        // Back-to-back fetches 0 and 4, then grant withheld at PC=8
        repeat (4) applyStimulus();
        checkOutput("pc_at_8", pc_o, 32'h8);
        gntAllow = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("nogrant_req", 32'(reqSeen), 32'd1);
            checkOutput("nogrant_addr", addrSeen, 32'h8);
        end
        gntAllow = 1'b1;
        repeat (4) applyStimulus();

        // Redirect while WAIT with a slow response: stale word must be dropped
        memLatency = 3;
        applyStimulus();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        applyStimulus();
        redirect_i = 1'b0;
        memLatency = 1;
        checkOutput("redirect_pc", pc_o, 32'h0000_0100);
        checkOutput("drop_no_req", 32'(imem_req_o), 32'd0);
        runUntilValid("redirect_timeout");
        checkOutput("redirect_ifid_pc", ifid_pc_o, 32'h0000_0100);

        // Ungranted redirect to 0x10, then stall with the next word landing in the skid
        gntAllow      = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0010;
        applyStimulus();
        redirect_i = 1'b0;
        gntAllow   = 1'b1;
        #1;
        checkOutput("retarget_req", 32'(imem_req_o), 32'd1);
        checkOutput("retarget_addr", imem_addr_o, 32'h0000_0010);
        repeat (2) applyStimulus();
        checkOutput("stall_start_pc", ifid_pc_o, 32'h0000_0010);
        stall_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            checkOutput("stall_hold_pc", ifid_pc_o, 32'h0000_0010);
            if (i >= 2) checkOutput("skid_full_no_req", 32'(reqSeen), 32'd0);
        end
        stall_i = 1'b0;
        applyStimulus();
        checkOutput("skid_drain_pc", ifid_pc_o, 32'h0000_0014);
        applyStimulus();
        checkOutput("after_drain_req", 32'(reqSeen), 32'd1);
        checkOutput("after_drain_addr", addrSeen, 32'h0000_0018);

        // Redirect and stall together with the skid full
        applyStimulus();
        stall_i = 1'b1;
        repeat (2) applyStimulus();
        checkOutput("skid_full_req", 32'(imem_req_o), 32'd0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        applyStimulus();
        redirect_i = 1'b0;
        #1;
        checkOutput("flush_skid_req", 32'(imem_req_o), 32'd1);
        checkOutput("flush_skid_addr", imem_addr_o, 32'h0000_0200);
        stall_i = 1'b0;
        runUntilValid("flush_timeout");
        checkOutput("flush_target_pc", ifid_pc_o, 32'h0000_0200);

        // Granted redirect to the top of memory, then PC wrap
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        applyStimulus();
        redirect_i = 1'b0;
        checkOutput("top_pc", pc_o, 32'hFFFF_FFFC);
        runUntilValid("wrap_timeout");
        checkOutput("wrap_ifid_pc", ifid_pc_o, 32'hFFFF_FFFC);
        checkOutput("wrap_pc", pc_o, 32'h0000_0000);

        // Asynchronous reset in the middle of a WAIT
        repeat (2) applyStimulus();
        checkOutput("pre_rst_pc", pc_o, 32'h0000_0004);
        stall_i    = 1'b1;
        memLatency = 3;
        applyStimulus();
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_req", 32'(imem_req_o), 32'd0);
        checkOutput("async_rst_pc", pc_o, RESET_PC);
        checkOutput("async_rst_valid", 32'(ifid_valid_o), 32'd0);
        checkOutput("async_rst_ifid_pc", ifid_pc_o, 32'h0);
        checkOutput("async_rst_instr", ifid_instr_o, NOP);
        @(negedge clk);
        rst           = 1'b1;
        stall_i       = 1'b0;
        memLatency    = 1;
        imem_rvalid_i = 1'b0;
        resetModel();
        #1;
        checkOutput("rerelease_addr", imem_addr_o, RESET_PC);
        runUntilValid("rerelease_timeout");
        checkOutput("rerelease_ifid_pc", ifid_pc_o, RESET_PC);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/if_fetch_pc.md
Name: if_fetch_pc

Overview:
- Fetch-stage front end of the 5-stage core.
- Owns the architectural fetch PC and drives a single-outstanding instruction-memory request/response interface.
- Buffers the returned instruction into the IF/ID boundary with stall and flush support.
- Exports the current fetch PC to the downstream PC+4 adder and the IF/ID register.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
stall_i  input  1  decode not accepting; hold IF/ID outputs
redirect_i  input  1  branch/jump/trap taken; flush and refetch
redirect_pc_i  input  32  target address; bits [1:0] forced to 0
pc_o  output  32  current fetch PC, to PC+4 adder
imem_req_o  output  1  fetch request
imem_addr_o  output  32  request address (= pc_o)
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  response data valid
imem_rdata_i  input  32  instruction word
ifid_valid_o  output  1  IF/ID holds a live instruction
ifid_pc_o  output  32  PC of that instruction
ifid_instr_o  output  32  instruction word

Behaviour:
- Reset (rst=0, async):
  - pc_o=RESET_PC; state=FETCH.
  - ifid_valid_o=0, ifid_pc_o=0, ifid_instr_o=32'h0000_0013 (NOP).
  - Skid buffer empty.
  - imem_req_o=0 while rst is low. It rises combinationally in the first cycle after release.
- Reset mid-operation: all state cleared, and any in-flight response is dropped. The memory is reset by the same rst.
- States FETCH, WAIT, DROP; at most one outstanding request.
- FETCH:
  - imem_req_o=1 unless the skid buffer is full; imem_addr_o=pc_o.
  - gnt & !redirect -> WAIT.
  - gnt & redirect -> DROP; pc<=redirect_pc.
  - !gnt & redirect -> stay FETCH; pc<=redirect_pc. The address may change while ungranted.
- WAIT:
  - imem_req_o=0.
  - rvalid & !redirect -> deliver {pc, rdata}; pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); -> FETCH.
  - rvalid & redirect -> discard data; pc<=redirect_pc; -> FETCH.
  - !rvalid & redirect -> pc<=redirect_pc; -> DROP.
- DROP:
  - imem_req_o=0.
  - rvalid -> discard; -> FETCH.
  - redirect -> pc<=redirect_pc. Another redirect in the same cycle as rvalid still goes to FETCH with the new pc.
- Delivery to IF/ID:
  - If !stall_i, or ifid_valid_o=0, the IF/ID registers load next cycle and ifid_valid_o=1.
  - Otherwise the word goes into the 1-entry skid buffer.
  - While the skid buffer is full, FETCH raises no request.
  - When stall_i drops, the skid contents move into IF/ID on the next edge and the skid empties.
- stall_i=1 with no new word: IF/ID outputs hold.
- stall_i=0 with no new word and empty skid: ifid_valid_o<=0.
- Flush: redirect_i clears ifid_valid_o and the skid next cycle, regardless of stall_i (flush beats stall). ifid_pc_o and ifid_instr_o may keep stale values.
- Latency: gnt in cycle N, rvalid in N+1 -> ifid_valid_o=1 in N+2. Peak throughput is 1 instruction per 2 cycles.
- pc_o updates only on edges; it never glitches combinationally from redirect_i.

Test Plan:
- Reset release, gnt=1 every request, rvalid one cycle after gnt, rdata=PC^32'hA5A5_0000 -> ifid_pc_o=0,4,8,... every 2 cycles with matching instr; imem_addr_o has no gaps or repeats.
- gnt held low 3 cycles at PC=8 -> imem_req_o stays 1 with addr 8; no ifid_valid_o change; fetch resumes at 8 after gnt.
- redirect_i=1, redirect_pc_i=32'h0000_0103 while in WAIT -> DROP; the late response for the old PC is discarded; next request addr=32'h0000_0100; ifid_valid_o=0 until the 0x100 word arrives.
- stall_i=1 for 6 cycles with IF/ID valid at PC=0x10 -> IF/ID holds 0x10; the 0x14 word goes to skid; no request for 0x18 issued. stall_i drops -> 0x14 appears next cycle, then 0x18 is requested.
- redirect_i and stall_i high together with skid full -> ifid_valid_o=0 and skid empty next cycle; fetch resumes at the target.
- Redirect to 32'hFFFF_FFFC, then one delivery -> pc_o wraps to 32'h0000_0000. Async rst pulse mid-WAIT -> all outputs return to reset values immediately.
